// File: rtl/ks_pkg.sv
// Shared Kogge-Stone prefix primitives, used by the adder and the subtractor.
package ks_pkg;

    localparam int KS_MIN_WIDTH = 4;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic pg_t ks_combine(pg_t hi, pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One registered Kogge-Stone prefix level: bit i merges with bit i-DIST.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              valid_in,
    input  pg_t [WIDTH-1:0]   pg_in,
    output logic              valid_out,
    output pg_t [WIDTH-1:0]   pg_out
);

    pg_t [WIDTH-1:0] w_pg_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_merge
            assign w_pg_nxt[i] = ks_combine(pg_in[i], pg_in[i-DIST]);
        end else begin : g_pass
            assign w_pg_nxt[i] = pg_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            pg_out    <= '0;
        end else if (adv) begin
            valid_out <= valid_in;
            pg_out    <= w_pg_nxt;
        end
    end

endmodule

// File: rtl/ks_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor: a - b - bin with borrow-out and signed overflow.
module ks_subtractor_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    if (WIDTH < KS_MIN_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("ks_subtractor_pipe: WIDTH must be a power of two >= 4");
    end

    // Sideband that rides next to the prefix tree: original propagate, carry-in, sign bits.
    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic             cin;
        logic             a_msb;
        logic             b_msb;
    } side_t;

    logic                w_adv;
    pg_t   [WIDTH-1:0]   w_pg_in;
    side_t               w_side_in;
    pg_t   [WIDTH-1:0]   r_pg_p0;
    logic                r_vld_p0;
    side_t               r_side [0:LEVELS];
    pg_t   [WIDTH-1:0]   w_pg   [0:LEVELS];
    logic  [LEVELS:0]    w_vld;
    side_t               w_side_out;
    logic  [WIDTH-1:0]   w_gfin;

    assign out_valid = w_vld[LEVELS];
    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_pg_in[i].p = a[i] ^ ~b[i];
            w_pg_in[i].g = a[i] & ~b[i];
        end
        // Carry-in (inverted borrow) folded into bit 0 so the tree needs no extra input.
        w_pg_in[0].g = (a[0] & ~b[0]) | ((a[0] ^ ~b[0]) & ~bin);
        w_side_in.p     = a ^ ~b;
        w_side_in.cin   = ~bin;
        w_side_in.a_msb = a[WIDTH-1];
        w_side_in.b_msb = b[WIDTH-1];
    end

    // Stage 0 input register plus sideband shift chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_pg_p0  <= '0;
            for (int k = 0; k <= LEVELS; k++) begin
                r_side[k] <= '0;
            end
        end else if (w_adv) begin
            r_vld_p0  <= in_valid;
            r_pg_p0   <= w_pg_in;
            r_side[0] <= w_side_in;
            for (int k = 1; k <= LEVELS; k++) begin
                r_side[k] <= r_side[k-1];
            end
        end
    end

    assign w_pg[0]  = r_pg_p0;
    assign w_vld[0] = r_vld_p0;

    // Prefix levels 1..LEVELS, each one register deep
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        ks_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << (k - 1))
        ) u_lvl (
            .clk       (clk),
            .rst       (rst),
            .adv       (w_adv),
            .valid_in  (w_vld[k-1]),
            .pg_in     (w_pg[k-1]),
            .valid_out (w_vld[k]),
            .pg_out    (w_pg[k])
        );
    end

    // Output stage, combinational from the last register
    assign w_side_out = r_side[LEVELS];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_gfin[i] = w_pg[LEVELS][i].g;
        end
    end

    assign diff[0]         = w_side_out.p[0] ^ w_side_out.cin;
    assign diff[WIDTH-1:1] = w_side_out.p[WIDTH-1:1] ^ w_gfin[WIDTH-2:0];
    // Gated by valid so cleared data reads as "no borrow" instead of an all-zero carry.
    assign bout = out_valid & ~w_gfin[WIDTH-1];
    assign ovf  = (w_side_out.a_msb ^ w_side_out.b_msb) & (w_side_out.a_msb ^ diff[WIDTH-1]);

endmodule

// File: doc/ks_subtractor_pipe.md
# ks_subtractor_pipe

Pipelined, parameterized Kogge-Stone subtractor computing `a - b - bin` with borrow-out and signed-overflow flags. It is the inverse-direction companion to the team's Kogge-Stone adder. It reuses the same propagate/generate prefix structure, but registers every prefix level so it closes timing at widths the combinational adder cannot. It sits between operand-producing logic and result consumers, with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 16: operand width. Must be a power of two, ≥ 4.
- `LEVELS`, $clog2(WIDTH): number of prefix levels. Derived; not overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands this cycle.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1  borrow-out; 1 when unsigned `a < b + bin`.
- `ovf`  out  1  signed overflow of the two's-complement subtraction.

## Operation
- Subtraction is computed as `a + ~b + cin`, with `cin = ~bin`.
- Stage 0 (input register): `p = a ^ ~b`, `g = a & ~b`. Store `p`, `g`, `cin`, and the operand MSBs `a[W-1]` and `b[W-1]`.
- Carry-in handling: `cin` is folded into bit 0 as `g0' = g0 | (p0 & cin)`.
- Stages 1..LEVELS: Kogge-Stone prefix level `k` combines bit `i` with bit `i - 2^(k-1)` for all `i ≥ 2^(k-1)`.
  - Combine rule: `G = Gh | (Ph & Gl)`, `P = Ph & Pl`.
  - Lower bits pass through unchanged.
  - The original `p` vector travels alongside each level.
- Output stage (combinational from the last register):
  - `diff[0] = p0 ^ cin`; `diff[i] = p[i] ^ G[i-1]`.
  - `carry = G[W-1]`; `bout = ~carry`.
  - `ovf = (a_msb ^ b_msb) & (a_msb ^ diff[W-1])`.
- Flow control is one global stall: `adv = ~out_valid | out_ready`.
  - All pipeline registers, including their valid bits, load only when `adv = 1`.
  - `in_ready = adv`.
- Each valid bit shifts forward on `adv`. Stage 0's valid bit loads `in_valid`.
- Bubbles are permitted. A stage holding an invalid entry still consumes a slot; there is no bubble collapsing.

## Timing
- Latency: operands accepted at edge `n` (`in_valid & in_ready`) produce `out_valid = 1` after edge `n + LEVELS`, assuming no stall.
  - For WIDTH = 16, the latency is 4 cycles after the accepting edge, i.e. 5 registers in total: stage 0 plus 4 prefix levels.
- Throughput: one operation per cycle while `out_ready` is held high.
- Stall: when `out_valid & ~out_ready`, the following hold:
  - `diff`, `bout`, `ovf` and `out_valid` stay stable.
  - `in_ready = 0`, and no input is accepted.
- Simultaneous events: with `out_valid & out_ready & in_valid` in the same cycle, the result retires and the new operand enters on the same edge. There is no lost cycle.
- Reset: `rst` sampled high clears every valid bit.
  - `out_valid = 0` on the next cycle.
  - Data registers are cleared to 0, so `diff = 0`, `bout = 0` and `ovf = 0` after reset.
  - `in_ready = 1` during and after reset (`adv = 1` because `out_valid = 0`).
- Reset mid-operation: in-flight operations are discarded and never appear at the output.
- `in_valid` while `in_ready = 0`: the operand is not captured. The source must hold it.

## Structure
- Shared package `ks_pkg` holds:
  - the typedef `pg_t` (struct of `p`, `g`);
  - the function `ks_combine(pg_t hi, pg_t lo)`;
  - the constant for minimum width.
- The adder and subtractor both import `ks_pkg`.
- Sub-module `ks_prefix_level` implements one registered prefix level.
  - Parameters: `WIDTH`, `DIST`.
  - Ports: `clk`, `rst`, `adv`, `valid_in` / `valid_out`, and `pg` in/out.
  - Instantiate it LEVELS times in a generate loop.
- Stage 0 and the output logic stay in the top module.

## Test plan
- Reset, then `a = 16'h0005`, `b = 16'h0003`, `bin = 0` → after 4 cycles: `diff = 16'h0002`, `bout = 0`, `ovf = 0`.
- `a = 16'h0000`, `b = 16'h0001`, `bin = 0` → `diff = 16'hFFFF`, `bout = 1`, `ovf = 0`. Also `a = 16'h8000`, `b = 16'h0001` → `diff = 16'h7FFF`, `bout = 0`, `ovf = 1`.
- Borrow-in: `a = 16'h1234`, `b = 16'h1234`, `bin = 1` → `diff = 16'hFFFF`, `bout = 1`.
- Back-to-back stream of 8 operands with `out_ready = 1` → 8 consecutive `out_valid` cycles, in order, matching the reference model.
- Stall: stream with `out_ready` low for 3 cycles mid-stream → outputs held stable, `in_ready = 0`, no drop or duplicate.
- Assert `rst` with 3 operations in flight → `out_valid = 0` next cycle, outputs 0, none of the 3 results ever emitted.
